// File: rtl/skinny_iter_ctrl.sv
// skinny_iter_ctrl: iterative SKINNY-128-384(+) block-cipher sequencer.
// Holds state/TK1/TK2/TK3 and the 6-bit round-constant LFSR. Each RUN cycle
// pushes them through NUMRND unrolled rounds (skinny_rnd); after
// NROUNDS/NUMRND iterations the ciphertext is presented on ct_o.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; pt_i/tk1_i/tk2_i/tk3_i sampled on accept
//   ct_o                state register (ciphertext once out_valid)
//   out_valid/out_ready result handshake
//   busy                high while rounds are being computed
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | one iteration of NUMRND rounds per cycle
// DONE  | ciphertext held until out_ready

module skinny_rnd #(
  parameter int numrnd  = 8,
  parameter int fullcnt = 1
) (
  input  logic [127:0]             roundstate,
  input  logic [63+64*fullcnt:0]   roundcnt,
  input  logic [127:0]             roundtweak,
  input  logic [127:0]             roundkey,
  input  logic [6*numrnd-1:0]      constant,
  output logic [127:0]             nextstate,
  output logic [63+64*fullcnt:0]   nextcnt,
  output logic [127:0]             nexttweak,
  output logic [127:0]             nextkey
);
  localparam int CW = 64 + 64*fullcnt;
  // Tweakey cell permutation, nibble i = source cell of destination cell i.
  localparam logic [63:0] TK_PERM = 64'h9F8DAECB01234567;

  // With a half-width TK1 the lower half is zero on entry; after an even
  // number of permutations it is zero again, so only the upper half is kept.
  if (fullcnt == 0 && (numrnd % 2) != 0) begin : g_chk_half
    $error("skinny_rnd: fullcnt=0 needs an even numrnd");
  end

  function automatic logic [7:0] sbox(input logic [7:0] x_in);
    logic [7:0] x;
    x = x_in;
    for (int r = 0; r < 4; r++) begin
      x[0] = x[0] ^ ~(x[3] | x[2]);
      x[4] = x[4] ^ ~(x[7] | x[6]);
      if (r < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    end
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [63:0] rtk,
                                            input logic [5:0] c);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    b[0] = b[0] ^ {4'h0, c[3:0]};
    b[4] = b[4] ^ {6'h0, c[5:4]};
    b[8] = b[8] ^ 8'h02;
    for (int i = 0; i < 8; i++) b[i] = b[i] ^ rtk[63-8*i -: 8];
    // row r rotates right by r
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        t[4*r+j] = b[4*r + ((j - r + 4) % 4)];
    o = '0;
    for (int j = 0; j < 4; j++) begin
      o[127-8*j -: 8]      = t[j] ^ t[8+j] ^ t[12+j];
      o[127-8*(4+j) -: 8]  = t[j];
      o[127-8*(8+j) -: 8]  = t[4+j] ^ t[8+j];
      o[127-8*(12+j) -: 8] = t[j] ^ t[8+j];
    end
    return o;
  endfunction

  function automatic logic [127:0] tk_perm(input logic [127:0] k);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = k[127-8*int'(TK_PERM[63-4*i -: 4]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] tk2_lfsr(input logic [127:0] k);
    logic [127:0] o;
    o = k;
    for (int i = 0; i < 8; i++)
      o[127-8*i -: 8] = {k[126-8*i -: 7], k[127-8*i] ^ k[125-8*i]};
    return o;
  endfunction

  function automatic logic [127:0] tk3_lfsr(input logic [127:0] k);
    logic [127:0] o;
    o = k;
    for (int i = 0; i < 8; i++)
      o[127-8*i -: 8] = {k[120-8*i] ^ k[126-8*i], k[127-8*i -: 7]};
    return o;
  endfunction

  always_comb begin : p_unroll
    logic [127:0] s, k1, k2, k3;
    s  = roundstate;
    k1 = 128'(roundcnt) << (128 - CW);
    k2 = roundtweak;
    k3 = roundkey;
    for (int r = 0; r < numrnd; r++) begin
      s  = round_fn(s, k1[127:64] ^ k2[127:64] ^ k3[127:64], constant[6*r +: 6]);
      k1 = tk_perm(k1);
      k2 = tk2_lfsr(tk_perm(k2));
      k3 = tk3_lfsr(tk_perm(k3));
    end
    nextstate = s;
    nextcnt   = k1[127 -: CW];
    nexttweak = k2;
    nextkey   = k3;
  end
endmodule

module skinny_iter_ctrl #(
  parameter int NUMRND  = 8,
  parameter int NROUNDS = 40,
  parameter int FULLCNT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           pt_i,
  input  logic [63+64*FULLCNT:0] tk1_i,
  input  logic [127:0]           tk2_i,
  input  logic [127:0]           tk3_i,
  output logic [127:0]           ct_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);
  localparam int CW    = 64 + 64*FULLCNT;
  localparam int NITER = NROUNDS / NUMRND;
  localparam int ITW   = (NITER > 1) ? $clog2(NITER) : 1;
  localparam logic [ITW-1:0] IT_LAST = ITW'(NITER - 1);

  if (NUMRND < 1 || NROUNDS < NUMRND || (NROUNDS % NUMRND) != 0) begin : g_chk_rounds
    $error("skinny_iter_ctrl: NROUNDS must be a nonzero multiple of NUMRND");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm_q;
  logic [127:0]     st_q, k2_q, k3_q;
  logic [CW-1:0]    k1_q;
  logic [5:0]       rc_q;
  logic [ITW-1:0]   it_q;

  logic [127:0]        nextstate, nexttweak, nextkey;
  logic [CW-1:0]       nextcnt;
  logic [6*NUMRND-1:0] constant;
  logic [5:0]          rc_next;

  always_comb begin : p_const
    logic [5:0] c;
    c        = rc_q;
    constant = '0;
    for (int i = 0; i < NUMRND; i++) begin
      c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      constant[6*i +: 6] = c;
    end
    rc_next = c;
  end

  skinny_rnd #(.numrnd(NUMRND), .fullcnt(FULLCNT)) u_rnd (
    .roundstate (st_q),
    .roundcnt   (k1_q),
    .roundtweak (k2_q),
    .roundkey   (k3_q),
    .constant   (constant),
    .nextstate  (nextstate),
    .nextcnt    (nextcnt),
    .nexttweak  (nexttweak),
    .nextkey    (nextkey)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      k1_q  <= '0;
      k2_q  <= '0;
      k3_q  <= '0;
      rc_q  <= '0;
      it_q  <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          st_q  <= pt_i;
          k1_q  <= tk1_i;
          k2_q  <= tk2_i;
          k3_q  <= tk3_i;
          rc_q  <= '0;
          it_q  <= '0;
          fsm_q <= RUN;
        end
        RUN: begin
          st_q <= nextstate;
          k1_q <= nextcnt;
          k2_q <= nexttweak;
          k3_q <= nextkey;
          rc_q <= rc_next;
          it_q <= it_q + ITW'(1);
          if (it_q == IT_LAST) fsm_q <= DONE;
        end
        DONE: if (out_ready) begin
          it_q  <= '0;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN);
  assign ct_o      = st_q;
endmodule
